icache_fetch_responder: RTL and testbench

Direct-mapped instruction cache that answers the fetch-side PC/BUSY_WAIT handshake driven by PC_UNIT. On a hit it returns INSTRUCTION in the same cycle with BUSY_WAIT low. On a miss it holds BUSY_WAIT high, fetches a 128-bit block from instruction memory, and fills the line. It sits between PC_UNIT and the instruction memory model.

---
 rtl/icache_fetch_responder.sv | 153 +++++++++++++++
 tb/tb_icache_fetch_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fetch_responder.sv
// Direct-mapped instruction cache answering the PC / BUSY_WAIT fetch handshake.
// Latency: a hit returns INSTRUCTION combinationally in the same cycle; a miss stalls L+3 cycles (L = memory busy cycles).
// Backpressure: BUSY_WAIT holds the PC unit while a miss is outstanding; MEM_BUSY_WAIT holds the cache in FETCH.
module icache_fetch_responder #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSY_WAIT,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSY_WAIT
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [127:0]          data_q [LINES];

    // Block address of the outstanding miss; its low bits double as the line index.
    logic [27:0]           blk_q, blk_d;
    logic [127:0]          buf_q, buf_d;
    logic [31:0]           instr_q, instr_d;

    logic [1:0]            pc_offset;
    logic [INDEX_BITS-1:0] pc_index;
    logic [TAG_BITS-1:0]   pc_tag;
    logic                  pc_unused;

    logic                  hit;
    logic [127:0]          line_dat;
    logic [31:0]           hit_word;
    logic                  fill_we;
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  busy;
    logic                  mread;

    assign pc_offset = PC[3:2];
    assign pc_index  = PC[3+INDEX_BITS:4];
    assign pc_tag    = PC[31:4+INDEX_BITS];
    // Byte offset within a word is meaningless for instruction fetch.
    assign pc_unused = ^PC[1:0];

    assign fill_idx  = blk_q[INDEX_BITS-1:0];
    assign fill_tag  = blk_q[27:INDEX_BITS];

    // Tag lookup written as an OR over lines so an unknown PC cannot make hit unknown while all lines are invalid.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LINES; i++) begin
            if (valid_q[i] && (pc_index == INDEX_BITS'(i)) && (tag_q[i] == pc_tag)) begin
                hit = 1'b1;
            end
        end
    end

    // Word select from the indexed line.
    always_comb begin
        line_dat = data_q[pc_index];
        hit_word = line_dat[31:0];
        case (pc_offset)
            2'd0:    hit_word = line_dat[31:0];
            2'd1:    hit_word = line_dat[63:32];
            2'd2:    hit_word = line_dat[95:64];
            default: hit_word = line_dat[127:96];
        endcase
    end

    // Miss-handling FSM: next state, latched miss address, fill strobe and handshake outputs.
    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        buf_d   = buf_q;
        instr_d = instr_q;
        fill_we = 1'b0;
        busy    = 1'b0;
        mread   = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    instr_d = hit_word;
                end else begin
                    busy    = 1'b1;
                    blk_d   = PC[31:4];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy  = 1'b1;
                mread = 1'b1;
                if (!MEM_BUSY_WAIT) begin
                    buf_d   = MEM_READDATA;
                    state_d = FILL;
                end
            end
            FILL: begin
                busy    = 1'b1;
                fill_we = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gating with RESET keeps the handshake quiet for the whole reset window, independent of PC.
    assign BUSY_WAIT   = busy && !RESET;
    assign MEM_READ    = mread && !RESET;
    assign MEM_ADDRESS = blk_q;
    // While stalled, keep presenting the last word handed out.
    assign INSTRUCTION = (state_q == IDLE && hit) ? hit_word : instr_q;

    // Control state and valid bits; reset aborts any miss in flight so no partial fill lands.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            valid_q <= '0;
            blk_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            instr_q <= instr_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Line buffer and tag/data arrays; contents are qualified by valid_q so no reset is needed.
    always_ff @(posedge CLK) begin
        buf_q <= buf_d;
        if (fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= buf_q;
        end
    end

endmodule

// File: tb/tb_icache_fetch_responder.sv
module tb_icache_fetch_responder;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSY_WAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSY_WAIT;

    always #5 CLK = ~CLK;

    icache_fetch_responder #(.INDEX_BITS(3)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSY_WAIT    (BUSY_WAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSY_WAIT(MEM_BUSY_WAIT)
    );

    int checks   = 0;
    int failures = 0;

    // Instruction memory contents: block 0 is {0x33,0x22,0x11,0x00}, other blocks get a distinct pattern.
    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        logic [31:0] hi;
        logic [31:0] lo;
        hi = 32'(wa[29:2]) * 32'h9E37_7900;
        lo = 32'(wa[1:0]) * 32'h11;
        return hi | lo;
    endfunction

    // Memory model: busy for 'lat' cycles after MEM_READ rises, data valid when busy falls.
    int lat = 0;
    int mem_cnt = 0;
    always @(posedge CLK) begin
        if (MEM_READ) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end
    assign MEM_BUSY_WAIT = MEM_READ && (mem_cnt < lat);
    assign MEM_READDATA  = {mem_word({MEM_ADDRESS, 2'd3}), mem_word({MEM_ADDRESS, 2'd2}),
                            mem_word({MEM_ADDRESS, 2'd1}), mem_word({MEM_ADDRESS, 2'd0})};

    // Reference: which block each of the 8 lines holds, plus expected responses.
    typedef struct {
        logic [31:0] instr;
        int          stall;
        int          mreads;
        logic [27:0] blk;
    } exp_t;

    exp_t        exp_q[$];
    bit          mv[8];
    logic [24:0] mt[8];

    task automatic predict(input logic [31:0] pc, input int l);
        exp_t e;
        int   ln;
        bit   miss;
        ln       = int'(pc[6:4]);
        miss     = !mv[ln] || (mt[ln] != pc[31:7]);
        e.instr  = mem_word(pc[31:2]);
        e.stall  = miss ? l + 3 : 0;
        e.mreads = miss ? l + 1 : 0;
        e.blk    = pc[31:4];
        exp_q.push_back(e);
        if (miss) begin
            mv[ln] = 1'b1;
            mt[ln] = pc[31:7];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mv[i] = 1'b0;
    endtask

    // Monitor: accumulates stall and read cycles, scores each non-busy cycle as one response.
    bit mon_en = 1'b0;
    int stall = 0;
    int mreads = 0;
    int resp_cnt = 0;
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && !RESET) begin
            if (BUSY_WAIT) begin
                stall = stall + 1;
                if (MEM_READ) begin
                    mreads = mreads + 1;
                    checks = checks + 1;
                    if (exp_q.size() == 0 || MEM_ADDRESS != exp_q[0].blk) begin
                        failures = failures + 1;
                        $display("FAIL mem_address: got %h expected %h", MEM_ADDRESS,
                                 (exp_q.size() == 0) ? 28'h0 : exp_q[0].blk);
                    end
                end
            end else begin
                checks = checks + 1;
                if (MEM_READ !== 1'b0) begin
                    failures = failures + 1;
                    $display("FAIL mem_read_idle: got %b expected 0", MEM_READ);
                end
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    failures = failures + 1;
                    $display("FAIL unexpected_response: instr %h with no pending fetch", INSTRUCTION);
                end else begin
                    e = exp_q.pop_front();
                    if (INSTRUCTION !== e.instr) begin
                        failures = failures + 1;
                        $display("FAIL instruction: blk %h got %h expected %h", e.blk, INSTRUCTION, e.instr);
                    end
                    checks = checks + 1;
                    if (stall != e.stall) begin
                        failures = failures + 1;
                        $display("FAIL stall_cycles: blk %h got %0d expected %0d", e.blk, stall, e.stall);
                    end
                    checks = checks + 1;
                    if (mreads != e.mreads) begin
                        failures = failures + 1;
                        $display("FAIL mem_read_cycles: blk %h got %0d expected %0d", e.blk, mreads, e.mreads);
                    end
                end
                stall    = 0;
                mreads   = 0;
                resp_cnt = resp_cnt + 1;
            end
        end else begin
            stall  = 0;
            mreads = 0;
        end
    end

    task automatic finish_run();
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic wait_resp();
        int  start;
        bit  got;
        start = resp_cnt;
        got   = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge CLK);
            #1;
            if (resp_cnt != start) got = 1'b1;
        end
        if (!got) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL response_timeout: got no response after 200 cycles, expected one");
            finish_run();
        end
    endtask

    task automatic fetch(input logic [31:0] pc, input int l);
        predict(pc, l);
        @(posedge CLK);
        #1;
        PC  = pc;
        lat = l;
        wait_resp();
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks = checks + 1;
        if (got !== want) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    // Leave reset with a first fetch already queued so the miss that starts at release is scored.
    task automatic release_with(input logic [31:0] pc, input int l);
        model_reset();
        predict(pc, l);
        PC     = pc;
        lat    = l;
        mon_en = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        wait_resp();
    endtask

    initial begin
        logic [31:0] rpc;
        RESET = 1'b1;
        PC    = 'x;
        #12;
        check_bit("reset_busy_wait", BUSY_WAIT, 1'b0);
        check_bit("reset_mem_read", MEM_READ, 1'b0);
        checks = checks + 1;
        if (MEM_ADDRESS !== 28'h0) begin
            failures = failures + 1;
            $display("FAIL reset_mem_address: got %h expected 0", MEM_ADDRESS);
        end
        checks = checks + 1;
        if (INSTRUCTION !== 32'h0) begin
            failures = failures + 1;
            $display("FAIL reset_instruction: got %h expected 0", INSTRUCTION);
        end

        // Cold miss on PC 0 with L=4, then sequential hits in the same block.
        release_with(32'h0000_0000, 4);
        fetch(32'h0000_0004, 4);
        fetch(32'h0000_0008, 4);
        fetch(32'h0000_000C, 4);

        // Branch target into a cold line.
        fetch(32'h0000_0064, 3);
        fetch(32'h0000_0060, 3);

        // Conflict on line 0: each access evicts the other.
        fetch(32'h0000_0000, 2);
        fetch(32'h0000_0080, 2);
        fetch(32'h0000_0000, 2);

        // Zero-latency memory.
        fetch(32'h0000_0200, 0);
        fetch(32'h0000_0204, 0);

        // Reset while the miss is in FETCH: outputs drop without a clock edge.
        mon_en = 1'b0;
        @(posedge CLK);
        #1;
        PC  = 32'h0000_0140;
        lat = 20;
        repeat (3) @(posedge CLK);
        #2;
        check_bit("fetch_mem_read", MEM_READ, 1'b1);
        check_bit("fetch_busy_wait", BUSY_WAIT, 1'b1);
        RESET = 1'b1;
        #1;
        check_bit("abort_mem_read", MEM_READ, 1'b0);
        check_bit("abort_busy_wait", BUSY_WAIT, 1'b0);
        release_with(32'h0000_0140, 3);
        fetch(32'h0000_0004, 1);

        // Randomized fetch stream over a small address window with occasional far addresses.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) rpc = $urandom;
            else                           rpc = $urandom & 32'h0000_07FF;
            fetch(rpc, int'($urandom_range(0, 5)));
        end

        mon_en = 1'b0;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            failures = failures + 1;
            $display("FAIL pending_responses: got %0d left expected 0", exp_q.size());
        end
        finish_run();
    end

endmodule
